// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared word size, address map, bus FSM and target decode types
package proc_pkg;

    localparam int WORD_SIZE = 16;

    localparam logic [WORD_SIZE-1:0] LED_ADDR = 16'h1000;
    localparam logic [WORD_SIZE-1:0] SW_ADDR  = 16'h3000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } bus_state_t;

    typedef enum logic [1:0] {
        T_RAM,
        T_LED,
        T_SW,
        T_NONE
    } bus_target_t;

    // RAM occupies the bottom of the map, so it is checked before the MMIO points
    function automatic bus_target_t decode_target(
        input logic [WORD_SIZE-1:0] addr,
        input logic [WORD_SIZE-1:0] ram_top
    );
        bus_target_t t;
        t = T_NONE;
        if (addr < ram_top) begin
            t = T_RAM;
        end else if (addr == LED_ADDR) begin
            t = T_LED;
        end else if (addr == SW_ADDR) begin
            t = T_SW;
        end
        return t;
    endfunction

endpackage

// File: rtl/data_ram.sv
// rtl/data_ram.sv - single-port synchronous RAM with registered read data
module data_ram #(
    parameter int DEPTH  = 256,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              Clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read-before-write: a write cycle returns the old word, which the bus discards
    always_ff @(posedge Clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_bus_ctrl.sv
// rtl/data_bus_ctrl.sv - processor data-port slave: wait-stated RAM, LED register, switch input
module data_bus_ctrl
    import proc_pkg::*;
#(
    parameter int RAM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int LED_BITS    = 10
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataWaitreq,
    input  logic [LED_BITS-1:0]  SW,
    output logic [LED_BITS-1:0]  LEDR
);

    localparam int                   AW       = $clog2(RAM_DEPTH);
    localparam logic [WORD_SIZE-1:0] RAM_TOP  = WORD_SIZE'(RAM_DEPTH);
    localparam logic [3:0]           CNT_INIT = (WAIT_CYCLES > 1) ? 4'(WAIT_CYCLES - 2) : 4'd0;

    bus_state_t            state, state_next;
    bus_target_t           tgt;
    logic [3:0]            cnt, cnt_next;
    logic [AW-1:0]         lat_addr;
    logic [WORD_SIZE-1:0]  lat_data;
    logic                  lat_wr;
    logic [LED_BITS-1:0]   led_q;
    logic [LED_BITS-1:0]   sw_meta, sw_sync;
    logic                  req, accept, led_we;
    logic                  ram_we;
    logic [AW-1:0]         ram_addr;
    logic [WORD_SIZE-1:0]  ram_wdata, ram_rdata;
    logic [WORD_SIZE-1:0]  led_ext, sw_ext;

    // Gating with Resetn keeps the combinational IDLE outputs quiet while held in reset
    assign req     = (ReadData | WriteData) & Resetn;
    assign tgt     = decode_target(DataAddr, RAM_TOP);
    assign led_ext = {{(WORD_SIZE-LED_BITS){1'b0}}, led_q};
    assign sw_ext  = {{(WORD_SIZE-LED_BITS){1'b0}}, sw_sync};
    assign LEDR    = led_q;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        DataWaitreq = 1'b0;
        DataIn      = '0;
        ram_we      = 1'b0;
        ram_addr    = lat_addr;
        ram_wdata   = lat_data;
        accept      = 1'b0;
        led_we      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (tgt == T_RAM) begin
                        accept      = 1'b1;
                        DataWaitreq = 1'b1;
                        // With one wait state the DONE-entry edge is the accept edge,
                        // so the RAM sees the live request that is being latched
                        ram_addr    = DataAddr[AW-1:0];
                        ram_wdata   = DataOut;
                        if (WAIT_CYCLES == 1) begin
                            state_next = DONE;
                            ram_we     = WriteData;
                        end else begin
                            state_next = WAIT;
                            cnt_next   = CNT_INIT;
                        end
                    end else if (WriteData) begin
                        led_we = (tgt == T_LED);
                    end else if (tgt == T_LED) begin
                        DataIn = led_ext;
                    end else if (tgt == T_SW) begin
                        DataIn = sw_ext;
                    end
                end
            end
            WAIT: begin
                DataWaitreq = 1'b1;
                if (cnt == 4'd0) begin
                    state_next = DONE;
                    ram_we     = lat_wr;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            DONE: begin
                DataIn     = lat_wr ? '0 : ram_rdata;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
            led_q    <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            sw_meta <= SW;
            sw_sync <= sw_meta;
            if (accept) begin
                lat_addr <= DataAddr[AW-1:0];
                lat_data <= DataOut;
                lat_wr   <= WriteData;
            end
            if (led_we) begin
                led_q <= DataOut[LED_BITS-1:0];
            end
        end
    end

    data_ram #(
        .DEPTH  (RAM_DEPTH),
        .WIDTH  (WORD_SIZE),
        .ADDR_W (AW)
    ) u_ram (
        .Clock (Clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
